pwm_bus_slave: RTL and testbench
================================

// Module: pwm_bus_slave
// PURPOSE
//  Bus responder for the PWM configuration writer: decodes cs/wr/rd cycles at
//  byte offsets 0x0/0x4/0x8 (CTRL/PERIOD/DUTY) into a register file.
//  Drives a single PWM output from a free-running period counter.
//  Sits between the sequencing writer and the actuator pin; supports read-back.
// PARAMETERS
//  DW       32   data/counter width (PERIOD, DUTY, counter, d_in, d_out)
//  AW       32   address width; offsets decoded from adr[3:2]
// PORTS
//  clk      in   1    system clock, all logic on rising edge
//  rst_n    in   1    asynchronous active-low reset
//  adr      in   AW   byte address of access
//  cs       in   1    chip select, access valid when high
//  wr       in   1    write strobe (qualified by cs)
//  rd       in   1    read strobe (qualified by cs)
//  d_in     in   DW   write data
//  d_out    out  DW   read data, valid while ack=1
//  ack      out  1    one-cycle access acknowledge
//  pwm_out  out  1    PWM waveform
//  irq      out  1    period-end interrupt (PWM_IRQ_EN only, else tied 0)
// BEHAVIOUR
//  Reset (rst_n=0, async): CTRL=PERIOD=DUTY=0, shadows=0, cnt=0, d_out=0,
//   ack=0, pwm_out=0, irq=0, status flag=0.
//  Decode: mapped iff adr[AW-1:4]==0; reg select=adr[3:2]; adr[1:0] ignored.
//   0x0 CTRL: bit0 EN, bit1 IRQ_EN (bit1 exists only with PWM_IRQ_EN); other bits read 0.
//   0x4 PERIOD, 0x8 DUTY; 0xC STATUS (PWM_IRQ_EN only, else unmapped).
//  Write: cs&wr sampled at edge N -> register holds d_in after edge N; ack=1
//   for the cycle after edge N. cs&wr&rd -> write only, d_out unchanged.
//  Read: cs&rd&!wr at edge N -> d_out=register value, ack=1 after edge N.
//   PERIOD/DUTY read back the written value, not the shadow.
//  Unmapped: write dropped, read returns 0; ack still asserted.
//  Back-to-back accesses (cs held, every cycle) allowed: one ack per cycle.
//  Counter: EN=0 -> cnt=0, pwm_out=0, shadows load continuously from regs.
//   EN=1 -> cnt counts 0..PERIOD_sh-1 then wraps to 0; at wrap shadows reload
//   PERIOD_sh<=PERIOD, DUTY_sh<=DUTY (glitch-free update at boundary only).
//   EN 0->1: first cnt=0 cycle uses shadows loaded while disabled.
//  Output: pwm_out registered = (cnt < DUTY_sh); 1-cycle latency from cnt.
//   PERIOD_sh==0 -> cnt held 0, pwm_out=0, no wrap events.
//   DUTY_sh==0 -> constant 0; DUTY_sh>=PERIOD_sh(>0) -> constant 1.
//  Write to PERIOD/DUTY in the wrap cycle: shadow takes the pre-write value;
//   new value applies at the following wrap.
//  EN cleared mid-period: cnt and pwm_out go 0 on next edge.
//  Comparisons unsigned, full DW width; cnt never exceeds PERIOD_sh-1.
// CONFIGURATION
//  PWM_IRQ_EN defined: STATUS @0xC bit0 = sticky WRAP flag, set on each wrap
//   while EN=1; cleared by writing 1 to bit0 (write 0 no effect); set and
//   clear in same cycle -> set wins. irq = flag & CTRL.IRQ_EN (registered).
//  PWM_IRQ_EN undefined: no flag logic, 0xC unmapped, CTRL bit1 reads 0, irq=0.
// TESTING
//  Reset mid-run: assert rst_n=0 with EN=1,pwm_out=1 -> all outputs 0 at once.
//  Write PERIOD=10, DUTY=3, CTRL=1 -> pwm_out high 3 cycles of every 10, ack
//   one cycle after each write.
//  Writer sequence: 0x8<-100, 0x4<-1000, 0x0<-1 -> 10% duty, period 1000 clks.
//  Change DUTY 3->7 mid-period -> current period stays 3 high, next 7 high.
//  Edges: DUTY=0 -> pwm_out=0; DUTY=12,PERIOD=10 -> constant 1; PERIOD=0 -> 0.
//  Read-back 0x4 after write 10 -> d_out=10; read 0x40 -> d_out=0, ack=1.
//  PWM_IRQ_EN: CTRL=3, PERIOD=4 -> irq rises after first wrap; write 1 to 0xC
//   -> irq drops; clear coinciding with wrap -> flag stays 1.

Source files
------------

// File: rtl/pwm_bus_slave_if.sv
// Register-access bus between the PWM configuration writer and the PWM responder.
// The master drives the address, strobes and write data; the slave returns read data and a one-cycle ack.
interface pwm_bus_slave_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] adr;
  logic          cs;
  logic          wr;
  logic          rd;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic          ack;

  modport master (output adr, cs, wr, rd, d_in, input d_out, ack);
  modport slave  (input adr, cs, wr, rd, d_in, output d_out, ack);
endinterface

// File: rtl/pwm_bus_slave.sv
// PWM responder: CTRL/PERIOD/DUTY registers drive one PWM pin; PWM_IRQ_EN adds a STATUS wrap flag and irq.
// ack/d_out follow an access by one cycle and pwm_out lags the counter by one cycle; there is no backpressure, so every access is acked.
module pwm_bus_slave #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_bus_slave_if.slave  bus,
  output logic            pwm_out,
  output logic            irq
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic          mapped;
  logic [1:0]    sel;
  logic          wr_acc;
  logic          rd_acc;
  logic          ctrl_en;
  logic          ctrl_irq_en;
  logic [DW-1:0] period_q;
  logic [DW-1:0] duty_q;
  logic [DW-1:0] period_sh;
  logic [DW-1:0] duty_sh;
  logic [DW-1:0] cnt;
  logic          wrap;
  logic          flag;
  logic [DW-1:0] rd_data;
  logic          unused_adr_bits;

  assign mapped          = (bus.adr[AW-1:4] == '0);
  assign sel             = bus.adr[3:2];
  assign wr_acc          = bus.cs & bus.wr;
  assign rd_acc          = bus.cs & bus.rd & ~bus.wr;
  assign unused_adr_bits = ^bus.adr[1:0];

  // Only counting states can wrap; a zero shadow period parks the counter.
  assign wrap = ctrl_en && (period_sh != '0) && (cnt >= period_sh - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en  <= 1'b0;
      period_q <= '0;
      duty_q   <= '0;
    end else if (wr_acc && mapped) begin
      case (sel)
        2'd0:    ctrl_en  <= bus.d_in[0];
        2'd1:    period_q <= bus.d_in;
        2'd2:    duty_q   <= bus.d_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (mapped) begin
      case (sel)
        2'd0: begin
          rd_data[0] = ctrl_en;
          rd_data[1] = ctrl_irq_en;
        end
        2'd1:    rd_data = period_q;
        2'd2:    rd_data = duty_q;
        default: rd_data[0] = flag;
      endcase
    end
  end

  // A simultaneous write and read strobe is a write; d_out keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ack   <= 1'b0;
      bus.d_out <= '0;
    end else begin
      bus.ack <= wr_acc | rd_acc;
      if (rd_acc) begin
        bus.d_out <= rd_data;
      end
    end
  end

  // Shadows track the registers while idle and otherwise change only at a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      period_sh <= '0;
      duty_sh   <= '0;
      pwm_out   <= 1'b0;
    end else if (!ctrl_en || (period_sh == '0)) begin
      cnt       <= '0;
      period_sh <= period_q;
      duty_sh   <= duty_q;
      pwm_out   <= 1'b0;
    end else begin
      pwm_out <= (cnt < duty_sh);
      if (wrap) begin
        cnt       <= '0;
        period_sh <= period_q;
        duty_sh   <= duty_q;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

`ifdef PWM_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_irq_en <= 1'b0;
    end else if (wr_acc && mapped && (sel == 2'd0)) begin
      ctrl_irq_en <= bus.d_in[1];
    end
  end

  // Write-one-to-clear; a wrap in the same cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (wrap) begin
        flag <= 1'b1;
      end else if (wr_acc && mapped && (sel == 2'd3) && bus.d_in[0]) begin
        flag <= 1'b0;
      end
      irq <= flag & ctrl_irq_en;
    end
  end
`else
  assign ctrl_irq_en = 1'b0;
  assign flag        = 1'b0;
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_bus_slave.sv
// Randomized bench for pwm_bus_slave: register and waveform behaviour is predicted from period/duty arithmetic.
`timescale 1ns/1ps
module tb_pwm_bus_slave;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic pwm_out;
  logic irq;

  pwm_bus_slave_if #(.AW(AW), .DW(DW)) bus ();

  pwm_bus_slave #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register-level model
  logic        m_en, m_irq_en, m_flag;
  logic [31:0] m_period, m_duty, last_dout;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:4] != 28'd0) return 32'd0;
    case (a[3:2])
      2'd0:    return {30'd0, m_irq_en, m_en};
      2'd1:    return m_period;
      2'd2:    return m_duty;
`ifdef PWM_IRQ_EN
      default: return {31'd0, m_flag};
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (a[31:4] == 28'd0) begin
      case (a[3:2])
        2'd0: begin
          m_en = d[0];
`ifdef PWM_IRQ_EN
          m_irq_en = d[1];
`endif
        end
        2'd1: m_period = d;
        2'd2: m_duty = d;
        default: begin
`ifdef PWM_IRQ_EN
          if (d[0]) m_flag = 1'b0;
`endif
        end
      endcase
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_d;
    bus.cs   = 1'b1;
    bus.wr   = w;
    bus.rd   = r;
    bus.adr  = a;
    bus.d_in = d;
    exp_d = (r && !w) ? model_read(a) : last_dout;
    if (w) model_write(a, d);
    @(negedge clk);
    chk("ack", {31'd0, bus.ack}, 32'd1);
    chk("d_out", bus.d_out, exp_d);
    last_dout = exp_d;
    bus.cs = 1'b0;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  // Waveform model: cycle k after enable shows phase (k-1) mod P of period (k-1)/P.
  int          cyc = 0;
  int          t0 = 0;
  int          pk;
  logic        chk_on = 1'b0;
  logic [31:0] cp, d_a, d_b, sw_idx;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic exp_pwm(input int k);
    logic [31:0] kk, per, ph, dd;
    if (cp == 32'd0) return 1'b0;
    kk  = 32'(k - 1);
    per = kk / cp;
    ph  = kk % cp;
    dd  = (per >= sw_idx) ? d_b : d_a;
    return ph < dd;
  endfunction

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      pk = cyc - t0;
      if (pk >= 1) chk("pwm", {31'd0, pwm_out}, {31'd0, exp_pwm(pk)});
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_pwm(input logic [31:0] ctrl);
    access(1'b1, 1'b0, 32'h0, ctrl);
    t0 = cyc;
    chk_on = 1'b1;
  endtask

  task automatic stop_pwm();
    chk_on = 1'b0;
    access(1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("pwm_off", {31'd0, pwm_out}, 32'd0);
  endtask

  task automatic run_cfg(input logic [31:0] p, input logic [31:0] d, input logic [1:0] lo, input int n);
    access(1'b1, 1'b0, 32'h8 | 32'(lo), d);
    access(1'b1, 1'b0, 32'h4 | 32'(lo), p);
    cp = p; d_a = d; d_b = d; sw_idx = 32'hFFFF_FFFF;
    start_pwm(32'h1);
    wait_cycles(n);
    stop_pwm();
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_irq_en = 1'b0; m_flag = 1'b0;
    m_period = 32'd0; m_duty = 32'd0; last_dout = 32'd0;
  endtask

  initial begin
    int          hi_cnt;
    int          op;
    logic [31:0] p, d, ra;

    bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
    bus.adr = '0; bus.d_in = '0;
    model_reset();
    cp = 32'd0; d_a = 32'd0; d_b = 32'd0; sw_idx = 32'hFFFF_FFFF;

    #1 rst_n = 1'b0;
    #11;
    chk("rst_ack", {31'd0, bus.ack}, 32'd0);
    chk("rst_dout", bus.d_out, 32'd0);
    chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ack_idle", {31'd0, bus.ack}, 32'd0);

    // Register read-back, decode and strobe combinations
    access(1'b0, 1'b1, 32'hC, 32'h0);
    access(1'b1, 1'b0, 32'h4, 32'd10);
    access(1'b0, 1'b1, 32'h4, 32'h0);
    access(1'b0, 1'b1, 32'h7, 32'h0);
    access(1'b0, 1'b1, 32'h40, 32'h0);
    access(1'b1, 1'b0, 32'h44, 32'hDEAD);
    access(1'b0, 1'b1, 32'h4, 32'h0);
    access(1'b1, 1'b1, 32'h8, 32'd5);
    access(1'b0, 1'b1, 32'h8, 32'h0);
    access(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
    access(1'b0, 1'b1, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ack_gap", {31'd0, bus.ack}, 32'd0);

    // PERIOD=10, DUTY=3, raised to 7 mid-period: the new duty starts at the next period
    access(1'b1, 1'b0, 32'h4, 32'd10);
    access(1'b1, 1'b0, 32'h8, 32'd3);
    cp = 32'd10; d_a = 32'd3; d_b = 32'd7; sw_idx = 32'd1;
    start_pwm(32'h1);
    wait_cycles(4);
    access(1'b1, 1'b0, 32'h8, 32'd7);
    wait_cycles(25);
    chk("irq_off", {31'd0, irq}, 32'd0);
    stop_pwm();

    // Asynchronous reset while the output is high
    access(1'b1, 1'b0, 32'h8, 32'd3);
    cp = 32'd10; d_a = 32'd3; d_b = 32'd3; sw_idx = 32'hFFFF_FFFF;
    start_pwm(32'h1);
    access(1'b0, 1'b1, 32'h4, 32'h0);
    chk("pwm_pre_rst", {31'd0, pwm_out}, 32'd1);
    chk_on = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("mid_rst_ack", {31'd0, bus.ack}, 32'd0);
    chk("mid_rst_dout", bus.d_out, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 1'b1, 32'h4, 32'h0);
    access(1'b0, 1'b1, 32'h0, 32'h0);

    // Duty/period edge cases
    run_cfg(32'd10, 32'd0, 2'd0, 25);
    run_cfg(32'd10, 32'd12, 2'd1, 25);
    run_cfg(32'd0, 32'd5, 2'd2, 12);
    run_cfg(32'd1, 32'd1, 2'd3, 6);

    // Writer sequence: 10% duty over a 1000-cycle period
    access(1'b1, 1'b0, 32'h8, 32'd100);
    access(1'b1, 1'b0, 32'h4, 32'd1000);
    cp = 32'd1000; d_a = 32'd100; d_b = 32'd100; sw_idx = 32'hFFFF_FFFF;
    start_pwm(32'h1);
    hi_cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (pwm_out) hi_cnt++;
    end
    chk("duty_10pct", 32'(hi_cnt), 32'd100);
    stop_pwm();

    // Random configurations with unrelated bus traffic while running
    for (int t = 0; t < 10; t++) begin
      p = 32'($urandom_range(0, 16));
      d = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                      : 32'($urandom_range(0, 20));
      access(1'b1, 1'b0, 32'h8 | 32'($urandom_range(0, 3)), d);
      access(1'b1, 1'b0, 32'h4 | 32'($urandom_range(0, 3)), p);
      cp = p; d_a = d; d_b = d; sw_idx = 32'hFFFF_FFFF;
      start_pwm(32'h1);
      repeat (2 * int'(p) + 6) begin
        op = $urandom_range(0, 3);
        if (op == 0) begin
          ra = 32'($urandom_range(0, 2)) << 2;
          access(1'b0, 1'b1, ra | 32'($urandom_range(0, 3)), 32'h0);
        end else if (op == 1) begin
          ra = (32'($urandom_range(1, 4095)) << 4) | 32'($urandom_range(0, 15));
          access(1'($urandom_range(0, 1)), 1'b1, ra, $urandom);
        end else begin
          @(negedge clk);
        end
      end
      stop_pwm();
    end

`ifdef PWM_IRQ_EN
    // Wrap flag and interrupt
    access(1'b1, 1'b0, 32'hC, 32'h1);
    access(1'b1, 1'b0, 32'h4, 32'd4);
    access(1'b1, 1'b0, 32'h8, 32'd1);
    access(1'b1, 1'b0, 32'h0, 32'h3);
    t0 = cyc;
    wait_cycles(4);
    chk("irq_before_wrap", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    m_flag = 1'b1;
    access(1'b0, 1'b1, 32'hC, 32'h0);
    access(1'b1, 1'b0, 32'hC, 32'h0);
    access(1'b1, 1'b0, 32'hC, 32'h1);
    @(negedge clk);
    chk("irq_drop", {31'd0, irq}, 32'd0);
    m_flag = 1'b1;
    wait_cycles(int'(32'd4 - 32'(cyc - t0) % 32'd4) - 1);
    access(1'b1, 1'b0, 32'hC, 32'h1);
    m_flag = 1'b1;
    access(1'b0, 1'b1, 32'hC, 32'h0);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    access(1'b1, 1'b0, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'hC, 32'h1);
    access(1'b0, 1'b1, 32'hC, 32'h0);
`else
    access(1'b1, 1'b0, 32'h0, 32'h3);
    access(1'b0, 1'b1, 32'h0, 32'h0);
    access(1'b0, 1'b1, 32'hC, 32'h0);
    chk("irq_tied", {31'd0, irq}, 32'd0);
    access(1'b1, 1'b0, 32'h0, 32'h0);
`endif

    wait_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
